dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the single-port data memory.
//  Port A is the CPU load/store stage; port B is the debug/DMA loader.
//  Shares the memory's address/write_en/read_en/data_in/data_out bus
//  round-robin, one access at a time, with a req/ack handshake per port.
//  Each port gets a registered read-data return.
// PARAMETERS
//  ADDR_W  32  address width, passed through to the memory
//  DATA_W  32  data width of both ports and the memory
// PORTS
//  clk           in   1       system clock, all state updates on posedge
//  reset_n       in   1       synchronous reset, active-low
//  a_req         in   1       port A request; hold high until a_ack
//  a_we          in   1       port A: 1 = write, 0 = read; stable while a_req
//  a_addr        in   ADDR_W  port A address; stable while a_req
//  a_wdata       in   DATA_W  port A write data; stable while a_req
//  a_ack         out  1       port A one-cycle completion pulse
//  a_rdata       out  DATA_W  port A read data; valid while a_ack is high, held after
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata   same as port A, for port B
//  mem_address   out  ADDR_W  to memory address
//  mem_write_en  out  1       to memory write_en
//  mem_read_en   out  1       to memory read_en
//  mem_data_in   out  DATA_W  to memory data_in
//  mem_data_out  in   DATA_W  from memory data_out (Z when read_en is low)
//  busy          out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset values: every output 0; state = IDLE; last_grant = B, so A wins the first tie.
//  States:
//   IDLE
//    - No request: stay in IDLE.
//    - One request: grant that port.
//    - Both requesting: grant the port that is not last_grant.
//    - On a grant: latch we/addr/wdata, set last_grant to the winner, go to ACCESS.
//   ACCESS (exactly 1 cycle)
//    - mem_address/mem_data_in come from the latched values.
//    - mem_write_en = latched_we & reset_n.
//    - mem_read_en = ~latched_we.
//    - Write commits at the ending edge.
//    - Read: mem_data_out is captured into the winner's rdata at the ending edge.
//      The other port's rdata is unchanged.
//    - Go to DONE.
//   DONE (1 cycle)
//    - Winner's ack = 1; mem enables = 0.
//    - Go to IDLE.
//  Outside ACCESS: mem_write_en and mem_read_en are 0; mem_address/mem_data_in hold
//   their last value. Memory data_out is never sampled outside ACCESS (it is Z there).
//  Latency: req high in IDLE at edge N -> ACCESS in cycle N..N+1 -> ack high in cycle
//   N+1..N+2. One transaction per 3 cycles.
//  Handshake:
//   - Requester drops req on the edge where it samples ack high.
//   - A req still high in IDLE after DONE is treated as a new request.
//   - req may rise in any state and waits until IDLE.
//   - Changing we/addr/wdata while req is high and not yet acked is illegal.
//  Fairness: with A and B both held high, grants alternate A,B,A,B.
//   No port waits more than one transaction.
//  Write-then-read of the same address (either port): the read returns the new data.
//  Reset mid-operation (reset_n low at any edge):
//   - State -> IDLE, all outputs -> 0, the pending transaction is dropped with no ack.
//   - mem_write_en is gated by reset_n, so no write commits at a reset edge.
// TESTING
//  1. Reset with a_req=b_req=1 -> all outputs 0, busy=0.
//     First grant after release goes to A.
//  2. A write addr 4 data 0xDEADBEEF -> mem_write_en=1 for exactly 1 cycle,
//     a_ack 2 cycles after grant edge. Then B read addr 4 -> b_rdata=0xDEADBEEF,
//     b_ack 1 cycle; a_rdata unchanged.
//  3. a_req and b_req held high for 6 transactions -> ack order A,B,A,B,A,B;
//     busy stays high except 1 IDLE cycle between transactions.
//  4. A read while idle -> mem_read_en=1 only in ACCESS; a_rdata never X/Z;
//     mem_write_en stays 0.
//  5. A write 0x12345678 to addr 8, reset_n pulled low during ACCESS -> no a_ack;
//     memory[8] keeps its old value; outputs 0 next cycle.
//  6. b_req raised during A's DONE cycle -> B granted from the next IDLE;
//     no ack overlap between ports.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one data memory port
// between the CPU load/store stage (A) and the debug/DMA loader (B).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic              last_b;
  logic              win_b;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant;
  logic              grant_b;

  // Next state and grant choice; on a tie the port not granted last wins
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_b  = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req && b_req) begin
          grant   = 1'b1;
          grant_b = ~last_b;
        end else if (a_req) begin
          grant   = 1'b1;
        end else if (b_req) begin
          grant   = 1'b1;
          grant_b = 1'b1;
        end
        if (grant) state_nx = ACCESS;
      end
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, grant history, request latch and per-port read return
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      win_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_b    <= grant_b;
        win_b     <= grant_b;
        lat_we    <= grant_b ? b_we    : a_we;
        lat_addr  <= grant_b ? b_addr  : a_addr;
        lat_wdata <= grant_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS && !lat_we) begin
        if (win_b) b_rdata <= mem_data_out;
        else       a_rdata <= mem_data_out;
      end
    end
  end

  // Memory strobes live only in ACCESS; a write never fires under reset
  always_comb begin
    mem_address  = lat_addr;
    mem_data_in  = lat_wdata;
    mem_write_en = (state == ACCESS) & lat_we & reset_n;
    mem_read_en  = (state == ACCESS) & ~lat_we;
    a_ack        = (state == DONE) & ~win_b;
    b_ack        = (state == DONE) & win_b;
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: memory model, vector table,
// ack scoreboard and hand-written reset/fairness/handshake sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, a_ack;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_ack;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_en, mem_read_en, busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  logic [31:0] mem [16] = '{
    32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
    32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
    32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
    32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};

  always @(posedge clk)
    if (mem_write_en) mem[mem_address[5:2]] <= mem_data_in;

  assign mem_data_out = mem_read_en ? mem[mem_address[5:2]] : 32'bz;

  typedef struct {
    bit          pb;
    bit          we;
    logic [31:0] rexp;
  } exp_t;

  typedef struct {
    bit          pb;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_a_rd = '0;
  logic [31:0] exp_b_rd = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  exp_t e;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (a_ack || b_ack)) begin
      chk("ack_overlap", a_ack & b_ack, 0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ack: got a_ack=%b b_ack=%b expected none", a_ack, b_ack);
      end else begin
        e = sb.pop_front();
        chk("ack_port", b_ack, e.pb);
        if (!e.we) begin
          if (e.pb) exp_b_rd = e.rexp;
          else      exp_a_rd = e.rexp;
        end
        chk("a_rdata_known", $isunknown(a_rdata), 0);
        chk("a_rdata", a_rdata, exp_a_rd);
        chk("b_rdata", b_rdata, exp_b_rd);
      end
    end
  end

  task automatic drive(input bit pb, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp);
    exp_t x;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    x.pb = pb; x.we = we; x.rexp = rexp;
    sb.push_back(x);
  endtask

  task automatic txn(input vec_t v, output int lat, output int wcnt, output int rcnt);
    @(negedge clk);
    drive(v.pb, v.we, v.addr, v.wdata, v.rexp);
    lat = 0; wcnt = 0; rcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      wcnt += int'(mem_write_en);
      rcnt += int'(mem_read_en);
      if (v.pb ? b_ack : a_ack) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++; fails++;
      $display("FAIL txn_timeout: got no ack expected ack within 10 cycles");
    end
    if (v.pb) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  vec_t v;
  int   lat, wcnt, rcnt, nack, idle, first;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D};
    tbl[4] = '{1'b0, 1'b0, 32'h08, 32'h0, 32'h22222222};
    tbl[5] = '{1'b1, 1'b0, 32'h3C, 32'h0, 32'hFFFFFFFF};

    // reset with both ports requesting
    reset_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h14; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {a_ack, b_ack, busy, mem_write_en, mem_read_en}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    sb.push_back('{1'b0, 1'b0, 32'h44444444});
    sb.push_back('{1'b1, 1'b0, 32'h55555555});
    reset_n = 1'b1;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first < 0 && (a_ack || b_ack)) first = int'(b_ack);
      if (a_ack) a_req = 1'b0;
      if (b_ack) begin
        b_req = 1'b0;
        break;
      end
    end
    chk("first_grant_a", first, 0);

    // single-port vector table
    for (int i = 0; i < 6; i++) begin
      txn(tbl[i], lat, wcnt, rcnt);
      if (i == 0) chk("write_ack_latency", lat, 2);
      if (tbl[i].we) begin
        chk("write_en_cycles", wcnt, 1);
        chk("write_no_read_en", rcnt, 0);
      end else begin
        chk("read_en_cycles", rcnt, 1);
        chk("read_no_write_en", wcnt, 0);
      end
    end

    // both held high for six transactions
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0C, 32'h0, 32'h33333333);
      drive(1'b1, 1'b0, 32'h3C, 32'h0, 32'hFFFFFFFF);
    end
    nack = 0; idle = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && nack >= 1) idle++;
      if (a_ack || b_ack) nack++;
      if (nack == 6) break;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("fair_ack_count", nack, 6);
    chk("fair_idle_cycles", idle, 5);

    // reset during a write's ACCESS cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h08, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("abort_in_access", mem_write_en, 1);
    reset_n = 1'b0;
    a_req = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_we_gated", mem_write_en, 0);
    @(negedge clk);
    chk("abort_ctrl", {a_ack, b_ack, busy, mem_write_en, mem_read_en}, 0);
    chk("abort_a_rdata", a_rdata, 0);
    chk("abort_mem_address", mem_address, 0);
    chk("abort_mem_data_in", mem_data_in, 0);
    exp_a_rd = '0; exp_b_rd = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_mem8", mem[2], 32'h22222222);
    v = '{1'b0, 1'b0, 32'h08, 32'h0, 32'h22222222};
    txn(v, lat, wcnt, rcnt);

    // B request rises during A's DONE cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30, 32'h5A5A5A5A, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ack) break;
    end
    chk("late_b_a_acked", a_ack, 1);
    a_req = 1'b0;
    drive(1'b1, 1'b0, 32'h30, 32'h0, 32'h5A5A5A5A);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b_ack) begin
        lat = i;
        break;
      end
    end
    b_req = 1'b0;
    chk("late_b_latency", lat, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
